fir_seq_ctrl: RTL

- Sequencer in front of the 3-tap adaptive FIR.
- Arbitrates the FIR's shared x_n input between coefficient loads and sample streaming.
- Counts out the FIR's post-reset setup window, then serialises host coefficient writes into the FIR's shift-in protocol (s_set_coeffs + x_n).
- Forwards samples with s_axis_fir_tvalid, inserting guard cycles so the FIR state machine never sees set_coeffs and tvalid overlap.

---
 rtl/fir_seq_ctrl_if.sv | 33 +++
 rtl/fir_seq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl_if.sv
// Host/FIR-facing signal bundle for fir_seq_ctrl.
// The master modport is the host side; the slave modport is the sequencer.
interface fir_seq_ctrl_if #(
    parameter int TAP_SIZE = 6,
    parameter int X_N_SIZE = 8
);
    logic                load_req;
    logic                cfg_valid;
    logic [TAP_SIZE-1:0] cfg_data;
    logic                cfg_ready;
    logic                cfg_done;
    logic                smp_valid;
    logic [X_N_SIZE-1:0] smp_data;
    logic                smp_ready;
    logic [X_N_SIZE-1:0] fir_x_n;
    logic                fir_tvalid;
    logic                fir_set_coeffs;
    logic                busy;
    logic                err_timeout;
    logic [2:0]          state_dbg;

    modport master (
        output load_req, cfg_valid, cfg_data, smp_valid, smp_data,
        input  cfg_ready, cfg_done, smp_ready, fir_x_n, fir_tvalid,
               fir_set_coeffs, busy, err_timeout, state_dbg
    );

    modport slave (
        input  load_req, cfg_valid, cfg_data, smp_valid, smp_data,
        output cfg_ready, cfg_done, smp_ready, fir_x_n, fir_tvalid,
               fir_set_coeffs, busy, err_timeout, state_dbg
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequencer sharing the FIR x_n input between coefficient loads and sample streaming.
// Optional mid-load idle timeout is enabled by defining FIR_SEQ_TIMEOUT_EN.
module fir_seq_ctrl #(
    parameter int NBR_OF_TAPS  = 3,
    parameter int TAP_SIZE     = 6,
    parameter int X_N_SIZE     = 8,
    parameter int SETUP_CYCLES = 4,
    parameter int LOAD_TIMEOUT = 15
) (
    input logic          clk,
    input logic          reset,
    fir_seq_ctrl_if.slave bus
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; ready is combinational from state and load_req only.

    localparam int            CW         = $clog2(NBR_OF_TAPS + 1);
    localparam logic [CW-1:0] TAPS       = CW'(NBR_OF_TAPS);
    localparam logic [CW-1:0] LAST_TAP   = CW'(NBR_OF_TAPS - 1);
    localparam logic [3:0]    SETUP_LAST = 4'(SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [3:0]          setup_cnt, setup_cnt_d;
    logic [CW-1:0]       coeff_cnt, coeff_cnt_d;
    logic                gap_to_load, gap_to_load_d;
    logic [X_N_SIZE-1:0] x_n, x_n_d;
    logic                tvalid, tvalid_d;
    logic                set_coeffs, set_coeffs_d;
    logic                cfg_done, cfg_done_d;
    logic                cfg_ready, smp_ready;
    logic                cfg_hs, smp_hs;

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int            TW      = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(LOAD_TIMEOUT - 1);
    logic [TW-1:0] idle_cnt, idle_cnt_d;
    logic          err, err_d;
`else
    localparam int unused_load_timeout = LOAD_TIMEOUT;
`endif

    always_comb begin
        cfg_ready = (state == ST_LOAD) && (coeff_cnt < TAPS);
        smp_ready = ((state == ST_IDLE) || (state == ST_RUN)) && !bus.load_req;
        cfg_hs    = cfg_ready && bus.cfg_valid;
        smp_hs    = smp_ready && bus.smp_valid;
    end

    always_comb begin
        state_d       = state;
        setup_cnt_d   = setup_cnt;
        coeff_cnt_d   = coeff_cnt;
        gap_to_load_d = gap_to_load;
        x_n_d         = x_n;
        tvalid_d      = 1'b0;
        set_coeffs_d  = 1'b0;
        cfg_done_d    = 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
        idle_cnt_d    = idle_cnt;
        err_d         = err;
`endif
        case (state)
            ST_INIT: begin
                if (setup_cnt == SETUP_LAST) state_d = ST_IDLE;
                else setup_cnt_d = setup_cnt + 4'd1;
            end
            ST_IDLE: begin
                // load_req wins over a simultaneous sample; smp_ready is already low
                if (bus.load_req) begin
                    state_d     = ST_LOAD;
                    coeff_cnt_d = '0;
`ifdef FIR_SEQ_TIMEOUT_EN
                    idle_cnt_d  = '0;
                    err_d       = 1'b0;
`endif
                end else if (smp_hs) begin
                    x_n_d    = bus.smp_data;
                    tvalid_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.load_req) begin
                    state_d       = ST_GAP;
                    gap_to_load_d = 1'b1;
                end else if (smp_hs) begin
                    x_n_d    = bus.smp_data;
                    tvalid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cfg_hs) begin
                    set_coeffs_d = 1'b1;
                    x_n_d        = X_N_SIZE'($signed(bus.cfg_data));
                    coeff_cnt_d  = coeff_cnt + 1'b1;
`ifdef FIR_SEQ_TIMEOUT_EN
                    idle_cnt_d   = '0;
`endif
                    if (coeff_cnt == LAST_TAP) begin
                        cfg_done_d    = 1'b1;
                        state_d       = ST_GAP;
                        gap_to_load_d = 1'b0;
                    end
                end
`ifdef FIR_SEQ_TIMEOUT_EN
                // Abandon the load; taps already shifted in are left in the FIR
                else if (idle_cnt == TO_LAST) begin
                    err_d         = 1'b1;
                    state_d       = ST_GAP;
                    gap_to_load_d = 1'b0;
                end else begin
                    idle_cnt_d = idle_cnt + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_to_load) begin
                    state_d     = ST_LOAD;
                    coeff_cnt_d = '0;
`ifdef FIR_SEQ_TIMEOUT_EN
                    idle_cnt_d  = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            setup_cnt   <= '0;
            coeff_cnt   <= '0;
            gap_to_load <= 1'b0;
            x_n         <= '0;
            tvalid      <= 1'b0;
            set_coeffs  <= 1'b0;
            cfg_done    <= 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
            idle_cnt    <= '0;
            err         <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            setup_cnt   <= setup_cnt_d;
            coeff_cnt   <= coeff_cnt_d;
            gap_to_load <= gap_to_load_d;
            x_n         <= x_n_d;
            tvalid      <= tvalid_d;
            set_coeffs  <= set_coeffs_d;
            cfg_done    <= cfg_done_d;
`ifdef FIR_SEQ_TIMEOUT_EN
            idle_cnt    <= idle_cnt_d;
            err         <= err_d;
`endif
        end
    end

    assign bus.cfg_ready      = cfg_ready;
    assign bus.smp_ready      = smp_ready;
    assign bus.cfg_done       = cfg_done;
    assign bus.fir_x_n        = x_n;
    assign bus.fir_tvalid     = tvalid;
    assign bus.fir_set_coeffs = set_coeffs;
    assign bus.busy           = (state != ST_IDLE);
    assign bus.state_dbg      = state;
`ifdef FIR_SEQ_TIMEOUT_EN
    assign bus.err_timeout    = err;
`else
    assign bus.err_timeout    = 1'b0;
`endif

endmodule
